// File: rtl/alu_181_seq.sv
// Slice-sequential 74181-function ALU: one 4-bit slice evaluated per enabled clock
// through a single shared alu_74181, with carry and group lookahead terms held in registers.

module alu_74181 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic [3:0] s,
   input  logic       m,
   input  logic       cn_n,
   output logic [3:0] f,
   output logic       cn4_n,
   output logic       eq,
   output logic       p_n,
   output logic       g_n
);
   logic [3:0] p;
   logic [3:0] g;
   logic [3:0] h;
   logic [4:0] c;

   // p/g are the two operand terms the select lines build; the arithmetic result is their sum
   assign p = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
   assign g = (a & b & {4{s[3]}}) | (a & ~b & {4{s[2]}});
   assign h = p ^ g;

   assign c[0] = ~cn_n;
   assign c[1] = g[0] | (p[0] & c[0]);
   assign c[2] = g[1] | (p[1] & c[1]);
   assign c[3] = g[2] | (p[2] & c[2]);
   assign c[4] = g[3] | (p[3] & c[3]);

   assign f     = m ? ~h : (h ^ c[3:0]);
   assign cn4_n = ~c[4];
   assign eq    = &f;
   assign p_n   = ~(&p);
   assign g_n   = ~(g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]));
endmodule

module alu_181_seq #(
   parameter  int SLICES = 2,
   localparam int WIDTH  = 4 * SLICES
) (
   input  logic             clk,
   input  logic             rstb,
   input  logic             ena,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       s,
   input  logic             m,
   input  logic             cn_n,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] f,
   output logic             cn4_n,
   output logic             equal,
   output logic             p_n,
   output logic             g_n
);
   localparam int IW = (SLICES > 1) ? $clog2(SLICES) : 1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   // Handshake: start is taken on an enabled edge while busy=0; busy stays high for SLICES
   // enabled edges, then done is high for one enabled cycle with f and flags valid and held.
   logic [0:0]       state_q;
   logic [IW-1:0]    idx_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [3:0]       s_q;
   logic             m_q;
   logic             carry_n_q;
   logic             acc_p_q;
   logic             acc_g_q;
   logic             acc_eq_q;
   logic [WIDTH-1:0] f_q;
   logic             cn4_n_q;
   logic             equal_q;
   logic             p_n_q;
   logic             g_n_q;
   logic             done_q;

   logic [WIDTH-1:0] a_shift;
   logic [WIDTH-1:0] b_shift;
   logic [3:0]       sl_f;
   logic             sl_cn4_n;
   logic             sl_eq;
   logic             sl_p_n;
   logic             sl_g_n;
   logic             nxt_p;
   logic             nxt_g;
   logic             nxt_eq;
   logic             last;

   assign a_shift = a_q >> {idx_q, 2'b00};
   assign b_shift = b_q >> {idx_q, 2'b00};

   alu_74181 u_slice (
      .a     (a_shift[3:0]),
      .b     (b_shift[3:0]),
      .s     (s_q),
      .m     (m_q),
      .cn_n  (carry_n_q),
      .f     (sl_f),
      .cn4_n (sl_cn4_n),
      .eq    (sl_eq),
      .p_n   (sl_p_n),
      .g_n   (sl_g_n)
   );

   assign nxt_p  = acc_p_q & ~sl_p_n;
   assign nxt_g  = ~sl_g_n | (~sl_p_n & acc_g_q);
   assign nxt_eq = acc_eq_q & sl_eq;
   assign last   = (idx_q == IW'(SLICES - 1));

   always_ff @(posedge clk) begin
      if (!rstb) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         s_q       <= '0;
         m_q       <= 1'b0;
         carry_n_q <= 1'b1;
         acc_p_q   <= 1'b1;
         acc_g_q   <= 1'b0;
         acc_eq_q  <= 1'b1;
         f_q       <= '0;
         cn4_n_q   <= 1'b1;
         equal_q   <= 1'b0;
         p_n_q     <= 1'b1;
         g_n_q     <= 1'b1;
         done_q    <= 1'b0;
      end else if (ena) begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  a_q       <= a;
                  b_q       <= b;
                  s_q       <= s;
                  m_q       <= m;
                  carry_n_q <= cn_n;
                  idx_q     <= '0;
                  acc_p_q   <= 1'b1;
                  acc_g_q   <= 1'b0;
                  acc_eq_q  <= 1'b1;
                  f_q       <= '0;
                  state_q   <= ST_RUN;
               end
            end
            ST_RUN: begin
               for (int i = 0; i < SLICES; i++) begin
                  if (idx_q == IW'(i)) f_q[4*i +: 4] <= sl_f;
               end
               carry_n_q <= sl_cn4_n;
               acc_p_q   <= nxt_p;
               acc_g_q   <= nxt_g;
               acc_eq_q  <= nxt_eq;
               if (last) begin
                  cn4_n_q <= sl_cn4_n;
                  equal_q <= nxt_eq;
                  p_n_q   <= ~nxt_p;
                  g_n_q   <= ~nxt_g;
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end else begin
                  idx_q <= idx_q + IW'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy  = (state_q == ST_RUN);
   assign done  = done_q;
   assign f     = f_q;
   assign cn4_n = cn4_n_q;
   assign equal = equal_q;
   assign p_n   = p_n_q;
   assign g_n   = g_n_q;
endmodule

// File: tb/tb_alu_181_seq.sv
// Bench for alu_181_seq: SLICES=1/2/4/8 instances share stimulus; a word-level 74181 model
// with a latency counter predicts every output each cycle; directed vectors pin the model.

module tb_alu_181_seq;
   logic        clk = 1'b0;
   logic        rstb;
   logic        ena;
   logic        start;
   logic [31:0] a;
   logic [31:0] b;
   logic [3:0]  s;
   logic        m;
   logic        cn_n;

   logic [3:0]  busy_o, done_o, cn4_o, eq_o, p_o, g_o;
   logic [31:0] f_o [4];

   // model state, written only by the model process
   logic [3:0]  m_busy, m_done, m_cn4, m_eq, m_p, m_g;
   logic [31:0] m_f [4];
   logic [3:0]  e_cn4, e_eq, e_p, e_g;
   logic [31:0] e_f [4];
   int          m_cnt [4];

   // directed-vector literals, written only by the driver
   logic        chk_en = 1'b0;
   logic        lit_chk = 1'b0;
   logic [7:0]  lit_f;
   logic        lit_cn4, lit_eq, lit_p;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   genvar gk;
   generate
      for (gk = 0; gk < 4; gk++) begin : g_dut
         localparam int SL = 1 << gk;
         localparam int W  = 4 * SL;
         logic [W-1:0] f_w;
         alu_181_seq #(.SLICES(SL)) dut (
            .clk   (clk),
            .rstb  (rstb),
            .ena   (ena),
            .start (start),
            .a     (a[W-1:0]),
            .b     (b[W-1:0]),
            .s     (s),
            .m     (m),
            .cn_n  (cn_n),
            .busy  (busy_o[gk]),
            .done  (done_o[gk]),
            .f     (f_w),
            .cn4_n (cn4_o[gk]),
            .equal (eq_o[gk]),
            .p_n   (p_o[gk]),
            .g_n   (g_o[gk])
         );
         assign f_o[gk] = 32'(f_w);
      end
   endgenerate

   // Word-level 74181: arithmetic is X plus Y plus carry, logic mode from the function table
   function automatic void calc(input int w, input logic [31:0] av, input logic [31:0] bv,
                                input logic [3:0] sv, input logic mv, input logic cv,
                                output logic [31:0] fv, output logic c4, output logic eqv,
                                output logic pv, output logic gv);
      logic [63:0] mask, x, y, ua, ub, sum, gsum, lg;
      mask = (64'd1 << w) - 64'd1;
      ua = {32'd0, av} & mask;
      ub = {32'd0, bv} & mask;
      case (sv[1:0])
         2'd0: x = ua;
         2'd1: x = ua | ub;
         2'd2: x = (ua | ~ub) & mask;
         default: x = mask;
      endcase
      case (sv[3:2])
         2'd0: y = 64'd0;
         2'd1: y = ua & ~ub & mask;
         2'd2: y = ua & ub;
         default: y = ua;
      endcase
      case (sv)
         4'd0:  lg = ~ua;
         4'd1:  lg = ~(ua | ub);
         4'd2:  lg = ~ua & ub;
         4'd3:  lg = 64'd0;
         4'd4:  lg = ~(ua & ub);
         4'd5:  lg = ~ub;
         4'd6:  lg = ua ^ ub;
         4'd7:  lg = ua & ~ub;
         4'd8:  lg = ~ua | ub;
         4'd9:  lg = ~(ua ^ ub);
         4'd10: lg = ub;
         4'd11: lg = ua & ub;
         4'd12: lg = ~64'd0;
         4'd13: lg = ua | ~ub;
         4'd14: lg = ua | ub;
         default: lg = ua;
      endcase
      sum  = x + y + (cv ? 64'd0 : 64'd1);
      gsum = x + y;
      fv   = 32'(mv ? (lg & mask) : (sum & mask));
      c4   = ~sum[w];
      gv   = ~gsum[w];
      pv   = ~((x | y) == mask);
      eqv  = ({32'd0, fv} == mask);
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (!rstb) begin
            m_busy[k] = 1'b0; m_done[k] = 1'b0; m_cnt[k] = 0;
            m_f[k] = 32'd0; m_cn4[k] = 1'b1; m_eq[k] = 1'b0; m_p[k] = 1'b1; m_g[k] = 1'b1;
         end else if (ena) begin
            m_done[k] = 1'b0;
            if (m_busy[k]) begin
               m_cnt[k] = m_cnt[k] - 1;
               if (m_cnt[k] == 0) begin
                  m_busy[k] = 1'b0; m_done[k] = 1'b1;
                  m_f[k] = e_f[k]; m_cn4[k] = e_cn4[k]; m_eq[k] = e_eq[k];
                  m_p[k] = e_p[k]; m_g[k] = e_g[k];
               end
            end else if (start) begin
               calc(4 << k, a, b, s, m, cn_n, e_f[k], e_cn4[k], e_eq[k], e_p[k], e_g[k]);
               m_busy[k] = 1'b1; m_cnt[k] = 1 << k; m_f[k] = 32'd0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 4; k++) begin
            checks++;
            if ({busy_o[k], done_o[k]} !== {m_busy[k], m_done[k]}) begin
               failures++;
               $display("FAIL hs[%0d] t=%0t busy,done got=%b%b exp=%b%b", k, $time,
                        busy_o[k], done_o[k], m_busy[k], m_done[k]);
            end
            if (!m_busy[k]) begin
               checks++;
               if (f_o[k] !== m_f[k]) begin
                  failures++;
                  $display("FAIL f[%0d] t=%0t got=%h exp=%h", k, $time, f_o[k], m_f[k]);
               end
               checks++;
               if ({cn4_o[k], eq_o[k], p_o[k], g_o[k]} !== {m_cn4[k], m_eq[k], m_p[k], m_g[k]}) begin
                  failures++;
                  $display("FAIL flags[%0d] t=%0t cn4,eq,p,g got=%b%b%b%b exp=%b%b%b%b", k, $time,
                           cn4_o[k], eq_o[k], p_o[k], g_o[k], m_cn4[k], m_eq[k], m_p[k], m_g[k]);
               end
            end
         end
         if (lit_chk && m_done[1]) begin
            checks++;
            if (f_o[1][7:0] !== lit_f) begin
               failures++;
               $display("FAIL lit_f got=%h exp=%h", f_o[1][7:0], lit_f);
            end
            checks++;
            if ({cn4_o[1], eq_o[1], p_o[1]} !== {lit_cn4, lit_eq, lit_p}) begin
               failures++;
               $display("FAIL lit_flags cn4,eq,p got=%b%b%b exp=%b%b%b",
                        cn4_o[1], eq_o[1], p_o[1], lit_cn4, lit_eq, lit_p);
            end
            checks++;
            if ({m_f[1][7:0], m_cn4[1], m_eq[1], m_p[1]} !== {lit_f, lit_cn4, lit_eq, lit_p}) begin
               failures++;
               $display("FAIL model_pin got=%h,%b%b%b exp=%h,%b%b%b", m_f[1][7:0], m_cn4[1],
                        m_eq[1], m_p[1], lit_f, lit_cn4, lit_eq, lit_p);
            end
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (m_busy != 4'd0 && n < 1000) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic op(input logic [31:0] av, input logic [31:0] bv, input logic [3:0] sv,
                     input logic mv, input logic cv);
      a = av; b = bv; s = sv; m = mv; cn_n = cv;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic directed(input logic [7:0] av, input logic [7:0] bv, input logic [3:0] sv,
                           input logic mv, input logic cv, input logic [7:0] ef,
                           input logic ec4, input logic eeq, input logic ep, input logic mid);
      lit_f = ef; lit_cn4 = ec4; lit_eq = eeq; lit_p = ep;
      lit_chk = 1'b1;
      op({24'd0, av}, {24'd0, bv}, sv, mv, cv);
      if (mid) begin
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      wait_idle();
      @(negedge clk);
      lit_chk = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      rstb = 1'b0; ena = 1'b1; start = 1'b0;
      a = '0; b = '0; s = '0; m = 1'b0; cn_n = 1'b1;
      repeat (2) @(negedge clk);
      rstb = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);

      directed(8'h3C, 8'h55, 4'b1001, 1'b0, 1'b1, 8'h91, 1'b1, 1'b0, 1'b1, 1'b0);
      directed(8'hFF, 8'h01, 4'b1001, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      directed(8'h50, 8'h50, 4'b0110, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0);
      directed(8'h50, 8'h50, 4'b0110, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
      directed(8'hA5, 8'h0F, 4'b0110, 1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b1);

      // reset one cycle after the start edge aborts the operation
      op(32'h0000_003C, 32'h0000_0055, 4'b1001, 1'b0, 1'b1);
      rstb = 1'b0;
      @(negedge clk);
      rstb = 1'b1;
      repeat (10) @(negedge clk);
      directed(8'h3C, 8'h55, 4'b1001, 1'b0, 1'b1, 8'h91, 1'b1, 1'b0, 1'b1, 1'b0);

      for (int i = 0; i < 500; i++) begin
         int n;
         logic took;
         a = $urandom; b = $urandom; s = 4'($urandom_range(0, 15));
         m = 1'($urandom_range(0, 1)); cn_n = 1'($urandom_range(0, 1));
         start = 1'b1;
         ena = ($urandom_range(0, 3) != 0);
         took = 1'b0;
         n = 0;
         while (!took && n < 1000) begin
            @(posedge clk);
            took = ena;
            @(negedge clk);
            if (!took) ena = ($urandom_range(0, 3) != 0);
            n++;
         end
         start = 1'b0;
         n = 0;
         while (m_busy != 4'd0 && n < 1000) begin
            ena = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            n++;
         end
      end
      ena = 1'b1;
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
